// File: rtl/sprite_ram_arbiter.sv
// sprite_ram_arbiter: shares one sprite frame RAM between a VGA read path (A) and a game-logic read/write path (B)
// Ports: Clk, Reset_n (async active-low); a_* read request/ack/response; b_* read-write request/ack/response;
// ram_* drive a single-write, registered-read (1-cycle latency) RAM. Define SPRITE_MIRROR_EN to add a_flip/b_flip.
module sprite_ram_arbiter #(
  parameter int SPR_W = 48,
  parameter int SPR_H = 44,
  parameter int N_FRAMES = 1,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 5,
  parameter int STARVE_MAX = 4,
  parameter logic [DATA_W-1:0] TRANSP_IDX = '0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              a_req,
  input  logic [2:0]        a_frame,
  input  logic [5:0]        a_x,
  input  logic [5:0]        a_y,
`ifdef SPRITE_MIRROR_EN
  input  logic              a_flip,
  input  logic              b_flip,
`endif
  output logic              a_ack,
  output logic              a_rsp_valid,
  output logic [DATA_W-1:0] a_rsp_data,
  output logic              a_rsp_err,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [2:0]        b_frame,
  input  logic [5:0]        b_x,
  input  logic [5:0]        b_y,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] b_rsp_data,
  output logic              b_rsp_err,
  output logic [ADDR_W-1:0] ram_read_address,
  output logic [ADDR_W-1:0] ram_write_address,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [ADDR_W-1:0] FRAME_SZ = ADDR_W'(SPR_W * SPR_H);
  localparam logic [ADDR_W-1:0] ROW_SZ = ADDR_W'(SPR_W);
  localparam logic [ADDR_W-1:0] X_MAX = ADDR_W'(SPR_W - 1);
  logic [SW-1:0] starve_cnt;
  logic pend, owner_b, oor;
  logic b_win, rd, wr, in_range;
  logic [2:0] f;
  logic [5:0] x, y;
  logic [ADDR_W-1:0] xe, addr;
  always_comb begin
    b_win = b_req && (!a_req || starve_cnt == SW'(STARVE_MAX));
    a_ack = Reset_n && a_req && !b_win;
    b_ack = Reset_n && b_win;
    f = b_win ? b_frame : a_frame;
    x = b_win ? b_x : a_x;
    y = b_win ? b_y : a_y;
`ifdef SPRITE_MIRROR_EN
    // mirroring only remaps the address; the range check still sees the raw x
    xe = (b_win ? b_flip : a_flip) ? X_MAX - ADDR_W'(x) : ADDR_W'(x);
`else
    xe = ADDR_W'(x);
`endif
    in_range = ({26'd0, x} < SPR_W) && ({26'd0, y} < SPR_H) && ({29'd0, f} < N_FRAMES);
    addr = ADDR_W'(f) * FRAME_SZ + ADDR_W'(y) * ROW_SZ + xe;
    rd = a_ack || (b_ack && !b_we);
    wr = b_ack && b_we;
    ram_read_address = (rd && in_range) ? addr : '0;
    ram_we = wr && in_range;
    ram_write_address = ram_we ? addr : '0;
    ram_data_in = ram_we ? b_wdata : '0;
  end
  // one response slot suffices: every grant answers exactly one cycle later
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pend <= 1'b0;
      owner_b <= 1'b0;
      oor <= 1'b0;
      starve_cnt <= '0;
    end else begin
      pend <= rd || (wr && !in_range);
      owner_b <= b_ack;
      oor <= !in_range;
      starve_cnt <= (b_req && !b_ack) ? (starve_cnt == SW'(STARVE_MAX) ? starve_cnt : starve_cnt + 1'b1) : '0;
    end
  end
  always_comb begin
    a_rsp_valid = pend && !owner_b;
    b_rsp_valid = pend && owner_b;
    a_rsp_err = a_rsp_valid && oor;
    b_rsp_err = b_rsp_valid && oor;
    a_rsp_data = !a_rsp_valid ? '0 : oor ? TRANSP_IDX : ram_data_out;
    b_rsp_data = !b_rsp_valid ? '0 : oor ? TRANSP_IDX : ram_data_out;
  end
endmodule

// File: tb/tb_sprite_ram_arbiter.sv
// tb_sprite_ram_arbiter: vector table, corner sequences and randomized model check for sprite_ram_arbiter
module tb_sprite_ram_arbiter;
  localparam int SPR_W = 48;
  localparam int SPR_H = 44;
  localparam int NF = 1;
  localparam int SMAX = 4;
  logic Clk = 1'b0, Reset_n = 1'b0;
  logic a_req = 0, b_req = 0, b_we = 0, a_flip = 0, b_flip = 0;
  logic [2:0] a_frame = 0, b_frame = 0;
  logic [5:0] a_x = 0, a_y = 0, b_x = 0, b_y = 0;
  logic [4:0] b_wdata = 0, ram_data_out = 0, ram_data_in, a_rsp_data, b_rsp_data;
  logic a_ack, b_ack, a_rsp_valid, b_rsp_valid, a_rsp_err, b_rsp_err, ram_we;
  logic [18:0] ram_read_address, ram_write_address;
  logic [4:0] ram [0:4095];
  logic [4:0] shadow [0:4095];
  int checks = 0, errors = 0;
  sprite_ram_arbiter dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .a_req(a_req), .a_frame(a_frame), .a_x(a_x), .a_y(a_y),
`ifdef SPRITE_MIRROR_EN
    .a_flip(a_flip), .b_flip(b_flip),
`endif
    .a_ack(a_ack), .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data), .a_rsp_err(a_rsp_err),
    .b_req(b_req), .b_we(b_we), .b_frame(b_frame), .b_x(b_x), .b_y(b_y), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data), .b_rsp_err(b_rsp_err),
    .ram_read_address(ram_read_address), .ram_write_address(ram_write_address),
    .ram_we(ram_we), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );
  always #5 Clk = ~Clk;
  always @(posedge Clk) begin
    if (ram_we) ram[ram_write_address[11:0]] <= ram_data_in;
    ram_data_out <= ram[ram_read_address[11:0]];
  end
  typedef struct {
    int ar, af, ax, ay, br, bw, bf, bx, by, bd;
    int ea, eb, era, ewe, ewa, eav, ebv, eerr;
  } vec_t;
  vec_t vt [9];
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", n, act, exp, $time);
    end
  endtask
  task automatic set_in(input int ar, af, ax, ay, br, bw, bf, bx, by, bd);
    a_req = ar[0]; a_frame = 3'(af); a_x = 6'(ax); a_y = 6'(ay);
    b_req = br[0]; b_we = bw[0]; b_frame = 3'(bf); b_x = 6'(bx); b_y = 6'(by); b_wdata = 5'(bd);
  endtask
  task automatic next_cyc;
    @(posedge Clk);
    #1;
  endtask
  function automatic int addr_of(input int f, x, y, fl);
    return f * SPR_W * SPR_H + y * SPR_W + (fl != 0 ? SPR_W - 1 - x : x);
  endfunction
  function automatic int inr(input int f, x, y);
    return int'(x < SPR_W && y < SPR_H && f < NF);
  endfunction
  int scnt, pv, pb, perr, pd, ea, bw, a_acked, b_acked, aa, ba, af_i, bf_i;
  initial begin
    vt[0] = '{1,0,3,2,   0,0,0,0,0,0,     1,0,99,0,0,     1,0,0};
    vt[1] = '{0,0,0,0,   1,1,0,47,43,31,  0,1,0,1,2111,   0,0,0};
    vt[2] = '{1,0,10,5,  1,0,0,0,0,0,     1,0,250,0,0,    1,0,0};
    vt[3] = '{1,0,48,0,  0,0,0,0,0,0,     1,0,0,0,0,      1,0,1};
    vt[4] = '{0,0,0,0,   1,1,0,0,44,7,    0,1,0,0,0,      0,1,1};
    vt[5] = '{1,1,0,0,   0,0,0,0,0,0,     1,0,0,0,0,      1,0,1};
    vt[6] = '{0,0,0,0,   1,0,0,10,5,0,    0,1,250,0,0,    0,1,0};
    vt[7] = '{0,0,0,0,   0,0,0,0,0,0,     0,0,0,0,0,      0,0,0};
    vt[8] = '{0,0,0,0,   1,0,0,63,63,0,   0,1,0,0,0,      0,1,1};
    for (int i = 0; i < 4096; i++) ram[i] = 5'(i);
    set_in(1,0,3,2, 1,1,0,1,1,9);
    #2;
    chk("rst_a_ack", int'(a_ack), 0);
    chk("rst_b_ack", int'(b_ack), 0);
    chk("rst_raddr", int'(ram_read_address), 0);
    chk("rst_we", int'(ram_we), 0);
    chk("rst_a_rsp_valid", int'(a_rsp_valid), 0);
    chk("rst_b_rsp_valid", int'(b_rsp_valid), 0);
    chk("rst_a_rsp_data", int'(a_rsp_data), 0);
    set_in(0,0,0,0, 0,0,0,0,0,0);
    next_cyc; next_cyc;
    Reset_n = 1'b1;
    next_cyc;
    // test-plan read at (3,2): address 99, data is the preloaded ram[99]
    set_in(1,0,3,2, 0,0,0,0,0,0);
    #3;
    chk("tp_a_ack", int'(a_ack), 1);
    chk("tp_raddr", int'(ram_read_address), 99);
    next_cyc;
    set_in(0,0,0,0, 0,0,0,0,0,0);
    #3;
    chk("tp_a_rsp_valid", int'(a_rsp_valid), 1);
    chk("tp_a_rsp_data", int'(a_rsp_data), 99 % 32);
    next_cyc;
    for (int i = 0; i < 9; i++) begin
      set_in(vt[i].ar, vt[i].af, vt[i].ax, vt[i].ay, vt[i].br, vt[i].bw, vt[i].bf, vt[i].bx, vt[i].by, vt[i].bd);
      #3;
      chk($sformatf("v%0d_a_ack", i), int'(a_ack), vt[i].ea);
      chk($sformatf("v%0d_b_ack", i), int'(b_ack), vt[i].eb);
      chk($sformatf("v%0d_raddr", i), int'(ram_read_address), vt[i].era);
      chk($sformatf("v%0d_we", i), int'(ram_we), vt[i].ewe);
      chk($sformatf("v%0d_waddr", i), int'(ram_write_address), vt[i].ewa);
      if (vt[i].ewe != 0) chk($sformatf("v%0d_wdata", i), int'(ram_data_in), vt[i].bd);
      next_cyc;
      set_in(0,0,0,0, 0,0,0,0,0,0);
      #3;
      chk($sformatf("v%0d_a_rsp_valid", i), int'(a_rsp_valid), vt[i].eav);
      chk($sformatf("v%0d_b_rsp_valid", i), int'(b_rsp_valid), vt[i].ebv);
      chk($sformatf("v%0d_a_rsp_err", i), int'(a_rsp_err), vt[i].eav & vt[i].eerr);
      chk($sformatf("v%0d_b_rsp_err", i), int'(b_rsp_err), vt[i].ebv & vt[i].eerr);
      if (vt[i].eerr != 0) chk($sformatf("v%0d_rsp_data", i), int'(a_rsp_data | b_rsp_data), 0);
      next_cyc;
    end
    // starvation: A wins four times, then B is forced in, then A again
    set_in(1,0,1,1, 1,0,0,2,2,0);
    for (int c = 0; c < 6; c++) begin
      #3;
      chk($sformatf("starve_c%0d_a_ack", c), int'(a_ack), c == 4 ? 0 : 1);
      chk($sformatf("starve_c%0d_b_ack", c), int'(b_ack), c == 4 ? 1 : 0);
      if (c > 0) chk($sformatf("starve_c%0d_b_rsp", c), int'(b_rsp_valid), c == 5 ? 1 : 0);
      next_cyc;
    end
    set_in(0,0,0,0, 0,0,0,0,0,0);
    next_cyc;
    // write (47,43) then read it back on the very next cycle
    set_in(0,0,0,0, 1,1,0,47,43,31);
    #3;
    chk("raw_we", int'(ram_we), 1);
    chk("raw_waddr", int'(ram_write_address), 2111);
    chk("raw_wdata", int'(ram_data_in), 31);
    next_cyc;
    set_in(0,0,0,0, 1,0,0,47,43,0);
    #3;
    chk("raw_raddr", int'(ram_read_address), 2111);
    chk("raw_b_rsp_after_wr", int'(b_rsp_valid), 0);
    next_cyc;
    set_in(0,0,0,0, 0,0,0,0,0,0);
    #3;
    chk("raw_b_rsp_valid", int'(b_rsp_valid), 1);
    chk("raw_b_rsp_data", int'(b_rsp_data), 31);
    chk("raw_b_rsp_err", int'(b_rsp_err), 0);
    next_cyc;
    // reset pulse during a pending B response drops it
    set_in(0,0,0,0, 1,0,0,5,5,0);
    next_cyc;
    set_in(0,0,0,0, 0,0,0,0,0,0);
    chk("mid_b_rsp_before", int'(b_rsp_valid), 1);
    Reset_n = 1'b0;
    #1;
    chk("mid_b_rsp_in_rst", int'(b_rsp_valid), 0);
    next_cyc;
    Reset_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #3;
      chk($sformatf("mid_b_rsp_after%0d", c), int'(b_rsp_valid), 0);
      chk($sformatf("mid_a_rsp_after%0d", c), int'(a_rsp_valid), 0);
      next_cyc;
    end
`ifdef SPRITE_MIRROR_EN
    set_in(1,0,0,1, 0,0,0,0,0,0);
    a_flip = 1'b1;
    #3;
    chk("mirror_raddr", int'(ram_read_address), 95);
    next_cyc;
    a_flip = 1'b0;
    set_in(0,0,0,0, 0,0,0,0,0,0);
    next_cyc;
`endif
    // randomized phase against a request-level model with its own memory image
    Reset_n = 1'b0;
    next_cyc;
    for (int i = 0; i < 4096; i++) begin
      ram[i] = 5'($urandom);
      shadow[i] = ram[i];
    end
    Reset_n = 1'b1;
    next_cyc;
    scnt = 0; pv = 0; pb = 0; perr = 0; pd = 0; a_acked = 1; b_acked = 1;
    for (int c = 0; c < 3000; c++) begin
      if (!a_req || a_acked != 0) begin
        a_req = ($urandom % 4) != 0;
        a_frame = ($urandom % 8) == 0 ? 3'($urandom_range(1, 7)) : 3'd0;
        a_x = 6'($urandom_range(0, 50));
        a_y = 6'($urandom_range(0, 46));
        a_flip = 1'($urandom);
      end
      if (!b_req || b_acked != 0) begin
        b_req = ($urandom % 3) != 0;
        b_we = 1'($urandom);
        b_frame = ($urandom % 8) == 0 ? 3'($urandom_range(1, 7)) : 3'd0;
        b_x = 6'($urandom_range(0, 50));
        b_y = 6'($urandom_range(0, 46));
        b_wdata = 5'($urandom);
        b_flip = 1'($urandom);
      end
      #3;
      chk("rnd_a_rsp_valid", int'(a_rsp_valid), pv & int'(pb == 0));
      chk("rnd_b_rsp_valid", int'(b_rsp_valid), pv & pb);
      chk("rnd_a_rsp_err", int'(a_rsp_err), pv & int'(pb == 0) & perr);
      chk("rnd_b_rsp_err", int'(b_rsp_err), pv & pb & perr);
      chk("rnd_a_rsp_data", int'(a_rsp_data), (pv != 0 && pb == 0 && perr == 0) ? pd : 0);
      chk("rnd_b_rsp_data", int'(b_rsp_data), (pv != 0 && pb != 0 && perr == 0) ? pd : 0);
`ifdef SPRITE_MIRROR_EN
      af_i = int'(a_flip); bf_i = int'(b_flip);
`else
      af_i = 0; bf_i = 0;
`endif
      bw = int'(b_req && (!a_req || scnt == SMAX));
      ea = int'(a_req) & int'(bw == 0);
      chk("rnd_a_ack", int'(a_ack), ea);
      chk("rnd_b_ack", int'(b_ack), bw);
      pv = 0;
      if (ea != 0) begin
        aa = addr_of(int'(a_frame), int'(a_x), int'(a_y), af_i);
        pv = 1; pb = 0; perr = int'(inr(int'(a_frame), int'(a_x), int'(a_y)) == 0);
        pd = perr != 0 ? 0 : int'(shadow[aa]);
        chk("rnd_raddr", int'(ram_read_address), perr != 0 ? 0 : aa);
        chk("rnd_we", int'(ram_we), 0);
      end else if (bw != 0) begin
        ba = addr_of(int'(b_frame), int'(b_x), int'(b_y), bf_i);
        perr = int'(inr(int'(b_frame), int'(b_x), int'(b_y)) == 0);
        pb = 1;
        if (b_we) begin
          pv = perr; pd = 0;
          chk("rnd_we", int'(ram_we), int'(perr == 0));
          chk("rnd_waddr", int'(ram_write_address), perr != 0 ? 0 : ba);
          chk("rnd_raddr", int'(ram_read_address), 0);
          if (perr == 0) begin
            chk("rnd_wdata", int'(ram_data_in), int'(b_wdata));
            shadow[ba] = b_wdata;
          end
        end else begin
          pv = 1;
          pd = perr != 0 ? 0 : int'(shadow[ba]);
          chk("rnd_raddr", int'(ram_read_address), perr != 0 ? 0 : ba);
          chk("rnd_we", int'(ram_we), 0);
        end
      end else begin
        chk("rnd_idle_raddr", int'(ram_read_address), 0);
        chk("rnd_idle_we", int'(ram_we), 0);
      end
      scnt = (b_req && bw == 0) ? (scnt < SMAX ? scnt + 1 : SMAX) : 0;
      a_acked = ea; b_acked = bw;
      next_cyc;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
